uart_xintf: RTL and testbench
=============================

# uart_xintf

UART-to-XINTF bridge. Byte commands arrive from a UART receiver and run single 16-bit write or read cycles on an external XINTF-style asynchronous parallel bus with chip-select zones 6 and 7. Read data goes back to a UART transmitter as two bytes. The block sits between the UART RX/TX cores and the external memory-mapped peripheral bus.

## Interface
- SETUP_CYC, default 2: cycles the address and zone are valid before the strobe falls (≥1).
- STROBE_CYC, default 4: cycles xwen/xrdn stay low (≥1).
- HOLD_CYC, default 2: cycles the address, zone and write data stay valid after the strobe rises (≥1).
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  UART RX byte-valid; level may last several cycles.
- rx_data_in  in  8  UART RX byte.
- tx_busy  in  1  UART TX busy.
- tx_start  out  1  one-cycle pulse that starts a TX byte.
- tx_data_out  out  8  TX byte; held stable from tx_start until the next load.
- xa  out  16  bus address.
- xd  inout  16  bus data; driven only during write cycles, high-Z otherwise.
- xwen  out  1  write strobe, active low.
- xrdn  out  1  read strobe, active low.
- zone_6_n  out  1  zone 6 chip select, active low.
- zone_7_n  out  1  zone 7 chip select, active low.

## Operation
- A byte is accepted on the rising edge of rx_valid, detected as a 0→1 change against a registered copy. A level held high for several cycles counts as one byte.
- Frame format:
  - Command byte: 0x77 ('w') or 0x72 ('r'). Any other byte received in IDLE is discarded.
  - Four address bytes, MSB first, forming A[31:0].
  - Write only: two data bytes, MSB first, forming D[15:0].
- Address decode:
  - xa = A[15:0].
  - A[31:24] = 0x01 selects zone 6; 0x02 selects zone 7.
  - Any other value: no zone is asserted, but the cycle timing runs unchanged. A read with no zone returns 0x0000.
- States: IDLE → ADDR (4 bytes) → {DATA (2 bytes, write)} → SETUP → STROBE → HOLD → (write: IDLE | read: TX_HI → TX_LO → IDLE).
- Write cycle:
  - Enter SETUP on the cycle after the last data byte.
  - xa, the zone select and xd = D are valid for SETUP_CYC cycles.
  - xwen is low for STROBE_CYC cycles.
  - HOLD_CYC cycles follow, then the zone deasserts and xd returns to high-Z.
- Read cycle:
  - Enter SETUP on the cycle after the 4th address byte.
  - xd stays high-Z throughout.
  - xrdn is low for STROBE_CYC cycles.
  - xd is registered into the internal 16-bit data_tx_1 on the last STROBE cycle.
  - HOLD_CYC cycles follow, with the zone still asserted.
- Read response:
  - TX_HI: when tx_busy=0, load tx_data_out=data_tx_1[15:8] and pulse tx_start for one cycle.
  - Wait one cycle, then wait for tx_busy=0.
  - TX_LO: send data_tx_1[7:0] the same way, then go to IDLE.
- Bytes arriving outside IDLE/ADDR/DATA are ignored.
- There is no inter-byte timeout.
- xwen and xrdn are never low together. At most one zone select is low at a time.

## Timing
- Reset values:
  - xwen, xrdn, zone_6_n, zone_7_n = 1.
  - xa = 0, xd = Z, tx_start = 0, tx_data_out = 0, data_tx_1 = 0.
  - State = IDLE, byte counters = 0.
- Asserting reset mid-operation aborts immediately: strobes and zones deassert, xd goes high-Z, any partial frame is dropped.
- xa holds its last value in IDLE.
- Strobes and selects are registered; there are no combinational paths from inputs to bus outputs.
- Write latency: the zone falls 1 cycle after the last data byte edge. Bus cycle length = SETUP_CYC + STROBE_CYC + HOLD_CYC.
- Read: tx_start fires at the earliest 1 cycle after HOLD ends.

## Test plan
- Write: send 0x77, 01 00 10 00, 0A A0 (rx_valid high 2 cycles per byte, 200 ns apart) → xa=0x1000, zone_6_n low for 8 cycles, xd=0x0AA0, xwen low for exactly 4 cycles, xrdn stays 1, no tx_start.
- Read: send 0x72, 01 00 10 00 with xd externally driven to 0xBEEF during the strobe → xrdn low 4 cycles, zone_6_n low, xd never driven by the DUT; then tx_start pulses with tx_data_out=0xBE, then 0xEF.
- TX backpressure: hold tx_busy=1 across the read response → no tx_start until tx_busy=0; second byte waits until tx_busy falls again.
- Zone 7 and no-zone: write with A=0x02003456 → zone_7_n low, xa=0x3456. Read with A=0x05000000 → no zone asserted, bytes 0x00, 0x00 returned.
- Garbage and long rx_valid: byte 0x41 in IDLE → no activity. Hold rx_valid high 5 cycles on one byte → counted once.
- Reset mid-cycle: assert reset during STROBE → xwen=1, zones=1, xd=Z immediately. A following clean write frame completes normally.

Source files
------------

// File: rtl/uart_xintf.sv
// UART-to-XINTF bridge: byte-framed commands from a UART RX core drive single
// 16-bit write/read cycles on an asynchronous parallel bus (zones 6 and 7).
module uart_xintf #(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data_in,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data_out,
   output logic [15:0] xa,
   inout  wire  [15:0] xd,
   output logic        xwen,
   output logic        xrdn,
   output logic        zone_6_n,
   output logic        zone_7_n,
   output logic [3:0]  o_dbg_state
);

   localparam int CW = 16;

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_DATA, S_SETUP, S_STROBE, S_HOLD, S_TX_HI, S_TX_GAP, S_TX_LO
   } state_t;

   // Handshake: a byte is taken on the 0->1 transition of rx_valid; a TX byte is
   // launched with a one-cycle tx_start pulse only while tx_busy is low.
   state_t         r_state;
   logic           r_rx_d;
   logic           r_is_read;
   logic [1:0]     r_byte_cnt;
   logic [31:0]    r_addr;
   logic [7:0]     r_wdata_hi;
   logic [CW-1:0]  r_cnt;
   logic [15:0]    r_xa;
   logic [15:0]    r_xd_out;
   logic           r_xd_oe;
   logic           r_xwen;
   logic           r_xrdn;
   logic           r_zone6_n;
   logic           r_zone7_n;
   logic           r_tx_start;
   logic [7:0]     r_tx_data;
   logic [15:0]    r_data_tx_1;

   logic           w_rx_edge;
   logic [31:0]    w_addr_next;
   logic [15:0]    w_data_next;
   logic           w_launch;
   logic [7:0]     w_launch_zone;
   logic [15:0]    w_launch_xa;

   assign w_rx_edge   = rx_valid & ~r_rx_d;
   assign w_addr_next = {r_addr[23:0], rx_data_in};
   assign w_data_next = {r_wdata_hi, rx_data_in};

   // A read launches on the 4th address byte, a write on the 2nd data byte.
   assign w_launch = w_rx_edge &&
                     (((r_state == S_ADDR) && (r_byte_cnt == 2'd3) && r_is_read) ||
                      ((r_state == S_DATA) && (r_byte_cnt == 2'd1)));
   assign w_launch_zone = r_is_read ? w_addr_next[31:24] : r_addr[31:24];
   assign w_launch_xa   = r_is_read ? w_addr_next[15:0]  : r_addr[15:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_rx_d      <= 1'b0;
         r_is_read   <= 1'b0;
         r_byte_cnt  <= 2'd0;
         r_addr      <= 32'h0;
         r_wdata_hi  <= 8'h0;
         r_cnt       <= '0;
         r_xa        <= 16'h0;
         r_xd_out    <= 16'h0;
         r_xd_oe     <= 1'b0;
         r_xwen      <= 1'b1;
         r_xrdn      <= 1'b1;
         r_zone6_n   <= 1'b1;
         r_zone7_n   <= 1'b1;
         r_tx_start  <= 1'b0;
         r_tx_data   <= 8'h0;
         r_data_tx_1 <= 16'h0;
      end else begin
         r_rx_d     <= rx_valid;
         r_tx_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rx_edge && (rx_data_in == 8'h77 || rx_data_in == 8'h72)) begin
                  r_is_read  <= (rx_data_in == 8'h72);
                  r_byte_cnt <= 2'd0;
                  r_state    <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (w_rx_edge) begin
                  r_addr     <= w_addr_next;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     r_byte_cnt <= 2'd0;
                     r_state    <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_rx_edge) begin
                  r_wdata_hi <= rx_data_in;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
               end
            end
            S_SETUP: begin
               if (r_cnt == '0) begin
                  r_state <= S_STROBE;
                  r_xwen  <= r_is_read;
                  r_xrdn  <= ~r_is_read;
                  r_cnt   <= CW'(STROBE_CYC - 1);
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_STROBE: begin
               if (r_cnt == '0) begin
                  r_state <= S_HOLD;
                  r_xwen  <= 1'b1;
                  r_xrdn  <= 1'b1;
                  r_cnt   <= CW'(HOLD_CYC - 1);
                  // Unselected reads return zero rather than a floating bus.
                  if (r_is_read)
                     r_data_tx_1 <= (r_zone6_n && r_zone7_n) ? 16'h0 : xd;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_HOLD: begin
               if (r_cnt == '0) begin
                  r_zone6_n <= 1'b1;
                  r_zone7_n <= 1'b1;
                  r_xd_oe   <= 1'b0;
                  r_state   <= r_is_read ? S_TX_HI : S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_TX_HI: begin
               if (!tx_busy) begin
                  r_tx_data  <= r_data_tx_1[15:8];
                  r_tx_start <= 1'b1;
                  r_state    <= S_TX_GAP;
               end
            end
            // One idle cycle gives the TX core time to raise tx_busy.
            S_TX_GAP: r_state <= S_TX_LO;
            S_TX_LO: begin
               if (!tx_busy) begin
                  r_tx_data  <= r_data_tx_1[7:0];
                  r_tx_start <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_launch) begin
            r_byte_cnt <= 2'd0;
            r_xa       <= w_launch_xa;
            r_zone6_n  <= (w_launch_zone != 8'h01);
            r_zone7_n  <= (w_launch_zone != 8'h02);
            r_xd_out   <= w_data_next;
            r_xd_oe    <= ~r_is_read;
            r_cnt      <= CW'(SETUP_CYC - 1);
            r_state    <= S_SETUP;
         end
      end
   end

   assign xd          = r_xd_oe ? r_xd_out : 16'bz;
   assign xa          = r_xa;
   assign xwen        = r_xwen;
   assign xrdn        = r_xrdn;
   assign zone_6_n    = r_zone6_n;
   assign zone_7_n    = r_zone7_n;
   assign tx_start    = r_tx_start;
   assign tx_data_out = r_tx_data;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_xintf.sv
// Bench for uart_xintf: table-driven and randomized bus frames checked against
// a frame-level reference model, plus hand-written multi-cycle corner cases.
module tb_uart_xintf;

   localparam int SETUP_CYC  = 2;
   localparam int STROBE_CYC = 4;
   localparam int HOLD_CYC   = 2;
   localparam int BUS_CYC    = SETUP_CYC + STROBE_CYC + HOLD_CYC;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data_in = 8'h0;
   logic        tx_busy = 1'b0;
   logic        tx_start;
   logic [7:0]  tx_data_out;
   logic [15:0] xa;
   wire  [15:0] xd;
   logic        xwen, xrdn, zone_6_n, zone_7_n;
   logic [3:0]  o_dbg_state;

   // Bench-side bus device: returns rd_val under the read strobe, 0 otherwise.
   logic        tb_drv_en = 1'b1;
   logic [15:0] tb_rd_val = 16'h0;
   logic        tb_hold = 1'b0;
   assign xd = tb_drv_en ? (xrdn ? 16'h0000 : tb_rd_val) : 16'bz;

   uart_xintf #(.SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC)) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data_in(rx_data_in),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_data_out(tx_data_out),
      .xa(xa), .xd(xd), .xwen(xwen), .xrdn(xrdn),
      .zone_6_n(zone_6_n), .zone_7_n(zone_7_n), .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_rd;
      logic [31:0] addr;
      logic [15:0] data;
      logic [15:0] rd_val;
      int          exp_z6;
      int          exp_z7;
      int          exp_wen;
      int          exp_rdn;
      int          exp_ntx;
      logic [15:0] exp_tx;
   } vec_t;

   int n_checks = 0;
   int n_err = 0;

   // Monitor state, sampled 1 ns after each rising edge.
   int          cyc = 0;
   int          m_z6, m_z7, m_wen, m_rdn, m_bad, m_xd_bad, m_stb_first;
   logic [15:0] m_xa, m_xd_w;
   logic [7:0]  got_tx[$];
   int          last_edge_cyc = 0;
   int          busy_left = 0;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (!zone_6_n) m_z6++;
      if (!zone_7_n) m_z7++;
      if (!xwen || !xrdn) begin
         if (m_wen + m_rdn == 0) m_stb_first = cyc;
         else if (xa !== m_xa) m_bad++;
         m_xa = xa;
      end
      if (!xwen) begin
         if (m_wen == 0) m_xd_w = xd;
         else if (xd !== m_xd_w) m_bad++;
         m_wen++;
      end
      if (!xrdn) m_rdn++;
      if (!xwen && !xrdn) m_bad++;
      if (!zone_6_n && !zone_7_n) m_bad++;
      if (tx_start) begin
         got_tx.push_back(tx_data_out);
         if (tx_busy) m_bad++;
      end
      if (tb_drv_en && xd !== (xrdn ? 16'h0000 : tb_rd_val)) m_xd_bad++;
   end

   // Simple UART TX model: busy for a few cycles after each start pulse.
   always @(negedge clk) begin
      if (tx_start) busy_left = $urandom_range(2, 8);
      else if (busy_left > 0) busy_left--;
      tx_busy = tb_hold | (busy_left != 0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      m_z6 = 0; m_z7 = 0; m_wen = 0; m_rdn = 0; m_bad = 0; m_xd_bad = 0;
      m_stb_first = 0; m_xa = 16'h0; m_xd_w = 16'h0;
      got_tx.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold);
      @(negedge clk);
      rx_data_in = b;
      rx_valid = 1'b1;
      last_edge_cyc = cyc;
      repeat (hold) @(negedge clk);
      rx_valid = 1'b0;
      repeat (18) @(negedge clk);
   endtask

   task automatic send_frame(input logic is_rd, input logic [31:0] addr,
                             input logic [15:0] data, input int hold);
      send_byte(is_rd ? 8'h72 : 8'h77, hold);
      for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8], hold);
      if (!is_rd) begin
         send_byte(data[15:8], hold);
         send_byte(data[7:0], hold);
      end
   endtask

   task automatic wait_tx(input int n, input int budget);
      int k;
      k = 0;
      while (got_tx.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (got_tx.size() < n) begin
         n_checks++;
         n_err++;
         $display("FAIL tx_timeout: got %0d bytes expected %0d", got_tx.size(), n);
      end
   endtask

   function automatic vec_t model(input logic is_rd, input logic [31:0] addr,
                                  input logic [15:0] data, input logic [15:0] rd_val);
      vec_t v;
      logic sel;
      v.is_rd = is_rd; v.addr = addr; v.data = data; v.rd_val = rd_val;
      sel = (addr[31:24] == 8'h01) || (addr[31:24] == 8'h02);
      v.exp_z6  = (addr[31:24] == 8'h01) ? BUS_CYC : 0;
      v.exp_z7  = (addr[31:24] == 8'h02) ? BUS_CYC : 0;
      v.exp_wen = is_rd ? 0 : STROBE_CYC;
      v.exp_rdn = is_rd ? STROBE_CYC : 0;
      v.exp_ntx = is_rd ? 2 : 0;
      v.exp_tx  = (is_rd && sel) ? rd_val : 16'h0;
      return v;
   endfunction

   task automatic run_frame(input vec_t v, input int hold);
      clear_mon();
      tb_drv_en = v.is_rd;
      tb_rd_val = v.rd_val;
      send_frame(v.is_rd, v.addr, v.data, hold);
      if (v.is_rd) wait_tx(2, 400);
      repeat (10) @(negedge clk);
      tb_drv_en = 1'b1;
   endtask

   task automatic check_frame(input vec_t v);
      chk("z6_cycles", m_z6, v.exp_z6);
      chk("z7_cycles", m_z7, v.exp_z7);
      chk("xwen_cycles", m_wen, v.exp_wen);
      chk("xrdn_cycles", m_rdn, v.exp_rdn);
      chk("tx_count", got_tx.size(), v.exp_ntx);
      chk("strobe_latency", m_stb_first - last_edge_cyc, 1 + SETUP_CYC);
      chk("xa_strobe", m_xa, v.addr[15:0]);
      chk("bus_rules", m_bad, 0);
      chk("xd_not_driven", m_xd_bad, 0);
      if (!v.is_rd) chk("xd_write", m_xd_w, v.data);
      if (got_tx.size() == 2) chk("tx_bytes", {got_tx[0], got_tx[1]}, v.exp_tx);
   endtask

   vec_t tbl[7];
   vec_t rv;

   initial begin
      tbl[0] = '{1'b0, 32'h01001000, 16'h0AA0, 16'h0000, 8, 0, 4, 0, 0, 16'h0000};
      tbl[1] = '{1'b1, 32'h01001000, 16'h0000, 16'hBEEF, 8, 0, 0, 4, 2, 16'hBEEF};
      tbl[2] = '{1'b1, 32'h01000002, 16'h0000, 16'h1234, 8, 0, 0, 4, 2, 16'h1234};
      tbl[3] = '{1'b0, 32'h02003456, 16'h5A5A, 16'h0000, 0, 8, 4, 0, 0, 16'h0000};
      tbl[4] = '{1'b1, 32'h05000000, 16'h0000, 16'hFFFF, 0, 0, 0, 4, 2, 16'h0000};
      tbl[5] = '{1'b0, 32'h7F00ABCD, 16'hFFFF, 16'h0000, 0, 0, 4, 0, 0, 16'h0000};
      tbl[6] = '{1'b1, 32'h0200C0DE, 16'h0000, 16'h8001, 0, 8, 0, 4, 2, 16'h8001};

      // Reset state
      clear_mon();
      repeat (3) @(negedge clk);
      chk("rst_xwen", xwen, 1'b1);
      chk("rst_xrdn", xrdn, 1'b1);
      chk("rst_zone6", zone_6_n, 1'b1);
      chk("rst_zone7", zone_7_n, 1'b1);
      chk("rst_xa", xa, 16'h0);
      chk("rst_xd_z", xd, 16'h0);
      chk("rst_tx_start", tx_start, 1'b0);
      chk("rst_tx_data", tx_data_out, 8'h0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_frame(tbl[i], 2);
         check_frame(tbl[i]);
         chk("xa_idle_hold", xa, tbl[i].addr[15:0]);
      end

      // Garbage byte in IDLE: no bus or TX activity, next frame unaffected.
      clear_mon();
      send_byte(8'h41, 2);
      repeat (20) @(negedge clk);
      chk("garbage_activity", m_z6 + m_z7 + m_wen + m_rdn + got_tx.size(), 0);
      run_frame(tbl[0], 2);
      check_frame(tbl[0]);

      // rx_valid held five cycles per byte: each byte counted once.
      run_frame(tbl[3], 5);
      check_frame(tbl[3]);

      // TX backpressure on both response bytes.
      clear_mon();
      tb_hold = 1'b1;
      tb_rd_val = 16'hCAFE;
      send_frame(1'b1, 32'h01000044, 16'h0, 2);
      repeat (30) @(negedge clk);
      chk("bp_none_sent", got_tx.size(), 0);
      tb_hold = 1'b0;
      wait_tx(1, 100);
      tb_hold = 1'b1;
      repeat (30) @(negedge clk);
      chk("bp_one_sent", got_tx.size(), 1);
      tb_hold = 1'b0;
      wait_tx(2, 100);
      if (got_tx.size() == 2) chk("bp_bytes", {got_tx[0], got_tx[1]}, 16'hCAFE);
      chk("bp_bus_rules", m_bad, 0);

      // Reset asserted during a write strobe.
      clear_mon();
      tb_drv_en = 1'b0;
      send_byte(8'h77, 2);
      send_byte(8'h01, 2); send_byte(8'h00, 2); send_byte(8'h20, 2); send_byte(8'h00, 2);
      send_byte(8'h12, 2);
      @(negedge clk);
      rx_data_in = 8'h34;
      rx_valid = 1'b1;
      for (int k = 0; k < 20 && xwen; k++) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
      rx_valid = 1'b0;
      chk("rst_mid_in_strobe", xwen, 1'b0);
      reset = 1'b0;
      tb_drv_en = 1'b1;
      #1;
      chk("rst_mid_xwen", xwen, 1'b1);
      chk("rst_mid_xrdn", xrdn, 1'b1);
      chk("rst_mid_zone6", zone_6_n, 1'b1);
      chk("rst_mid_zone7", zone_7_n, 1'b1);
      chk("rst_mid_xd_z", xd, 16'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      run_frame(tbl[0], 2);
      check_frame(tbl[0]);

      // Randomized frames against the reference model.
      for (int i = 0; i < 12; i++) begin
         logic [31:0] r32;
         logic [7:0]  top;
         int          sel;
         r32 = $urandom();
         sel = $urandom_range(0, 2);
         top = (sel == 0) ? 8'h01 : (sel == 1) ? 8'h02 : 8'($urandom_range(0, 255));
         rv = model(1'($urandom_range(0, 1)), {top, r32[23:0]},
                    16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
         run_frame(rv, $urandom_range(1, 4));
         check_frame(rv);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
